// File: rtl/code_fetch_unit.sv
// Code-fetch controller between the DW8051 program-fetch port and the program ROM.
// Optional one-entry sequential prefetch buffer: define CODE_PREFETCH_EN to enable it.
module code_fetch_unit #(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned WAIT_CYC = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              flush,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  output logic              busy,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_cs_n,
  output logic              rom_rd_n,
  input  logic [DATA_W-1:0] rom_data
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    PREF   = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYC - 1);

  state_t            state_q;
  logic [3:0]        cnt_q;
  logic              cpu_ready_q;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [ADDR_W-1:0] rom_addr_q;
  logic              strobe_n_q;
  logic              last_cyc;
  logic              req_seen;

  assign last_cyc  = (cnt_q == 4'd0);
  // A request coinciding with the ready pulse belongs to the fetch just answered.
  assign req_seen  = cpu_req && !cpu_ready_q;

  assign cpu_ready = cpu_ready_q;
  assign cpu_rdata = cpu_rdata_q;
  assign rom_addr  = rom_addr_q;
  assign rom_cs_n  = strobe_n_q;
  assign rom_rd_n  = strobe_n_q;
  assign busy      = (state_q != IDLE);

`ifdef CODE_PREFETCH_EN
  logic              pf_valid_q;
  logic              pf_pend_q;
  logic [ADDR_W-1:0] pf_addr_q;
  logic [DATA_W-1:0] pf_data_q;
  logic              pf_hit;

  assign pf_hit = pf_valid_q && (cpu_addr == pf_addr_q) && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cpu_ready_q <= 1'b0;
      cpu_rdata_q <= '0;
      rom_addr_q  <= '0;
      strobe_n_q  <= 1'b1;
      pf_valid_q  <= 1'b0;
      pf_pend_q   <= 1'b0;
      pf_addr_q   <= '0;
      pf_data_q   <= '0;
    end else begin
      cpu_ready_q <= 1'b0;
      if (flush) begin
        pf_valid_q <= 1'b0;
        pf_pend_q  <= 1'b0;
      end
      unique case (state_q)
        IDLE: begin
          if (req_seen) begin
            if (pf_hit) begin
              cpu_ready_q <= 1'b1;
              cpu_rdata_q <= pf_data_q;
              pf_valid_q  <= 1'b0;
              pf_addr_q   <= pf_addr_q + ADDR_W'(1);
              pf_pend_q   <= 1'b1;
            end else begin
              rom_addr_q <= cpu_addr;
              strobe_n_q <= 1'b0;
              cnt_q      <= CNT_LOAD;
              state_q    <= ACCESS;
            end
          end else if (pf_pend_q && !flush) begin
            // pf_addr_q already holds the next sequential address; pf_valid_q is clear.
            rom_addr_q <= pf_addr_q;
            strobe_n_q <= 1'b0;
            cnt_q      <= CNT_LOAD;
            pf_pend_q  <= 1'b0;
            state_q    <= PREF;
          end
        end
        ACCESS: begin
          if (last_cyc) begin
            cpu_rdata_q <= rom_data;
            cpu_ready_q <= 1'b1;
            strobe_n_q  <= 1'b1;
            pf_valid_q  <= 1'b0;
            pf_addr_q   <= rom_addr_q + ADDR_W'(1);
            pf_pend_q   <= !flush;
            state_q     <= IDLE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        PREF: begin
          if (req_seen && (flush || (cpu_addr != pf_addr_q))) begin
            rom_addr_q <= cpu_addr;
            strobe_n_q <= 1'b0;
            cnt_q      <= CNT_LOAD;
            pf_valid_q <= 1'b0;
            state_q    <= ACCESS;
          end else if (flush) begin
            strobe_n_q <= 1'b1;
            state_q    <= IDLE;
          end else if (last_cyc) begin
            strobe_n_q <= 1'b1;
            state_q    <= IDLE;
            if (req_seen) begin
              // CPU is already waiting on this address: forward the byte straight through.
              cpu_ready_q <= 1'b1;
              cpu_rdata_q <= rom_data;
              pf_addr_q   <= pf_addr_q + ADDR_W'(1);
              pf_pend_q   <= 1'b1;
            end else begin
              pf_data_q  <= rom_data;
              pf_valid_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: begin
          strobe_n_q <= 1'b1;
          state_q    <= IDLE;
        end
      endcase
    end
  end
`else
  logic unused_flush;
  assign unused_flush = flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cpu_ready_q <= 1'b0;
      cpu_rdata_q <= '0;
      rom_addr_q  <= '0;
      strobe_n_q  <= 1'b1;
    end else begin
      cpu_ready_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req_seen) begin
            rom_addr_q <= cpu_addr;
            strobe_n_q <= 1'b0;
            cnt_q      <= CNT_LOAD;
            state_q    <= ACCESS;
          end
        end
        ACCESS: begin
          if (last_cyc) begin
            cpu_rdata_q <= rom_data;
            cpu_ready_q <= 1'b1;
            strobe_n_q  <= 1'b1;
            state_q     <= IDLE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: begin
          strobe_n_q <= 1'b1;
          state_q    <= IDLE;
        end
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_code_fetch_unit.sv
// Self-checking bench for code_fetch_unit; prefetch cases run when CODE_PREFETCH_EN is defined.
module tb_code_fetch_unit;

  localparam int WC = 2;
`ifdef CODE_PREFETCH_EN
  localparam bit PF = 1'b1;
`else
  localparam bit PF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cpu_req = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic        flush = 1'b0;
  logic [7:0]  cpu_rdata;
  logic        cpu_ready;
  logic        busy;
  logic [15:0] rom_addr;
  logic        rom_cs_n;
  logic        rom_rd_n;
  logic [7:0]  rom_data;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];

  code_fetch_unit #(.ADDR_W(16), .DATA_W(8), .WAIT_CYC(WC)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_addr(cpu_addr), .flush(flush),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .busy(busy), .rom_addr(rom_addr),
    .rom_cs_n(rom_cs_n), .rom_rd_n(rom_rd_n), .rom_data(rom_data)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem(input logic [15:0] a);
    if (a == 16'h0010) return 8'hA5;
    return a[7:0] + {a[11:8], a[15:12]} + 8'h3C;
  endfunction

  always_comb rom_data = mem(rom_addr);

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Issue one fetch and compare data, latency, strobe cycles and ready pulse width.
  task automatic fetch(input logic [15:0] a, input logic [7:0] d, input int exp_lat,
                       input int exp_cs, input string nm);
    int lat = 0;
    int cs = 0;
    bit got = 0;
    bit strb_ok = 1;
    logic [7:0] e;
    cpu_req  = 1'b1;
    cpu_addr = a;
    exp_q.push_back(d);
    while (!got && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (!rom_cs_n) begin
        cs++;
        if (rom_addr !== a) strb_ok = 0;
      end
      if (rom_rd_n !== rom_cs_n) strb_ok = 0;
      if (cpu_ready === 1'b1) got = 1;
    end
    cpu_req = 1'b0;
    e = exp_q.pop_front();
    if (!got) begin
      total++;
      bad++;
      $display("FAIL %s timeout: no cpu_ready after %0d cycles, wanted data %0h", nm, lat, e);
    end else begin
      check({nm, " data"}, 32'(cpu_rdata), 32'(e));
      check({nm, " latency"}, 32'(lat), 32'(exp_lat));
      check({nm, " strobe cycles"}, 32'(cs), 32'(exp_cs));
      check({nm, " strobe addr"}, 32'(strb_ok), 32'd1);
      @(posedge clk);
      #1;
      check({nm, " ready pulse"}, 32'(cpu_ready), 32'd0);
      check({nm, " data held"}, 32'(cpu_rdata), 32'(e));
    end
  endtask

  typedef struct {
    logic [15:0] addr;
    bit          hit;
    logic [7:0]  data;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int rdy_cnt;
    vecs[0] = '{16'h0010, 1'b0, 8'hA5};
    vecs[1] = '{16'h0011, 1'b1, 8'h4D};
    vecs[2] = '{16'h0012, 1'b1, 8'h4E};
    vecs[3] = '{16'h1234, 1'b0, 8'h91};
    vecs[4] = '{16'h1235, 1'b1, 8'h92};
    vecs[5] = '{16'h7FFF, 1'b0, 8'h32};
    vecs[6] = '{16'h8000, 1'b1, 8'h44};
    vecs[7] = '{16'h0005, 1'b0, 8'h41};

    #1 rst_n = 1'b0;
    #3;
    check("reset ready", 32'(cpu_ready), 32'd0);
    check("reset rdata", 32'(cpu_rdata), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset rom_addr", 32'(rom_addr), 32'd0);
    check("reset cs_n", 32'(rom_cs_n), 32'd1);
    check("reset rd_n", 32'(rom_rd_n), 32'd1);
    @(negedge clk) rst_n = 1'b1;
    idle(2);

    for (int i = 0; i < 8; i++) begin
      fetch(vecs[i].addr, vecs[i].data, (PF && vecs[i].hit) ? 1 : WC + 1,
            (PF && vecs[i].hit) ? 0 : WC, $sformatf("vec%0d", i));
      idle(WC + 2);
    end

    // Address wrap: prefetch after 0xFFFF targets 0x0000.
    fetch(16'hFFFF, mem(16'hFFFF), WC + 1, WC, "wrap miss");
    if (PF) begin
      check("wrap pref addr", 32'(rom_addr), 32'h0000);
      check("wrap pref cs_n", 32'(rom_cs_n), 32'd0);
    end
    idle(WC + 2);
    fetch(16'h0000, mem(16'h0000), PF ? 1 : WC + 1, PF ? 0 : WC, "wrap next");
    idle(WC + 2);

    // Flush held through a demand access: access completes, no prefetch follows.
    flush = 1'b1;
    fetch(16'h0400, mem(16'h0400), WC + 1, WC, "flush access");
    check("flush no pref cs_n", 32'(rom_cs_n), 32'd1);
    flush = 1'b0;
    idle(WC + 2);
    fetch(16'h0401, mem(16'h0401), WC + 1, WC, "after flush");
    idle(WC + 2);

`ifdef CODE_PREFETCH_EN
    // Different address during PREF aborts it.
    fetch(16'h0100, mem(16'h0100), WC + 1, WC, "pref base");
    check("pref addr", 32'(rom_addr), 32'h0101);
    check("pref cs_n", 32'(rom_cs_n), 32'd0);
    fetch(16'h2000, mem(16'h2000), WC + 1, WC, "pref abort");
    idle(WC + 2);

    // Flush during PREF: strobes released next cycle, next fetch is a miss.
    fetch(16'h0100, mem(16'h0100), WC + 1, WC, "flush base");
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush pref cs_n", 32'(rom_cs_n), 32'd1);
    check("flush pref busy", 32'(busy), 32'd0);
    idle(WC + 2);
    fetch(16'h0101, mem(16'h0101), WC + 1, WC, "flush miss");
    idle(WC + 2);

    // Same address during PREF waits for the prefetch and forwards its byte.
    fetch(16'h0300, mem(16'h0300), WC + 1, WC, "wait base");
    fetch(16'h0301, mem(16'h0301), WC, WC - 1, "wait pref");
    idle(WC + 2);
`endif

    // Reset in the middle of a demand access.
    cpu_req  = 1'b1;
    cpu_addr = 16'h0042;
    @(posedge clk);
    #1;
    check("mid busy", 32'(busy), 32'd1);
    check("mid cs_n", 32'(rom_cs_n), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("mid rst cs_n", 32'(rom_cs_n), 32'd1);
    check("mid rst rd_n", 32'(rom_rd_n), 32'd1);
    check("mid rst busy", 32'(busy), 32'd0);
    check("mid rst addr", 32'(rom_addr), 32'd0);
    check("mid rst rdata", 32'(cpu_rdata), 32'd0);
    cpu_req = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    rdy_cnt = 0;
    repeat (3 * WC + 4) begin
      @(posedge clk);
      #1;
      if (cpu_ready === 1'b1) rdy_cnt++;
    end
    check("no ready after reset", 32'(rdy_cnt), 32'd0);
    check("idle after reset", 32'(busy), 32'd0);
    fetch(16'h0042, mem(16'h0042), WC + 1, WC, "post reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
